// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, FSM states and datapath control encodings for the multicycle RV32I core
package mc_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
    } state_t;

    // alu_op values are shared with the ALU control decoder
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational state -> datapath control table, with mem_ready/zero gating
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t     state_i,
    input  logic       is_store_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // per-state control word; fields not set stay 0
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALU;
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.imm_src   = is_store_i ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_MEM;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.mem_req    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALU_FN;
            end
            S_EXECI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.imm_src   = IMM_I;
                // ADDI must not let imm[10] be decoded as a SUB funct7 bit
                ctrl_o.alu_op    = (funct3_i == 3'b000) ? ALU_ADD : ALU_FN;
            end
            S_LUI: begin
                ctrl_o.alu_src_a = SRCA_ZERO;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.imm_src   = IMM_U;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALU_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                // only BEQ/BNE are legal; anything else goes to ILLEGAL without side effects
                ctrl_o.pc_write   = (funct3_i[2:1] == 2'b00) & (zero_i ^ funct3_i[0]);
                ctrl_o.instr_done = (funct3_i[2:1] == 2'b00);
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.pc_write   = 1'b1;
            end
            S_ILLEGAL: ctrl_o.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: main multicycle RV32I control FSM (state register, next-state logic, reset gating)
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       instr_done,
    output logic       illegal
);

    state_t state_q, state_d;
    ctrl_t  ctrl, ctrl_g;

    // next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = (funct3[2:1] == 2'b00) ? S_FETCH : S_ILLEGAL;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // state register; reset always returns to FETCH
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    mc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .is_store_i  (opcode[5]),
        .funct3_i    (funct3),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // rst silences every strobe in the same cycle so nothing partial reaches memory or the regfile
    assign ctrl_g     = rst ? '0 : ctrl;
    assign mem_req    = ctrl_g.mem_req;
    assign mem_write  = ctrl_g.mem_write;
    assign adr_src    = ctrl_g.adr_src;
    assign ir_write   = ctrl_g.ir_write;
    assign pc_write   = ctrl_g.pc_write;
    assign reg_write  = ctrl_g.reg_write;
    assign result_src = ctrl_g.result_src;
    assign alu_src_a  = ctrl_g.alu_src_a;
    assign alu_src_b  = ctrl_g.alu_src_b;
    assign alu_op     = ctrl_g.alu_op;
    assign imm_src    = ctrl_g.imm_src;
    assign instr_done = ctrl_g.instr_done;
    assign illegal    = ctrl_g.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scenario bench for the multicycle control FSM
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic       clk, rst, zero, mem_ready;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src;
    logic [5:0] en;
    int         n_chk, n_fail, done_cnt;
    logic       rw_seen;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .instr_done(instr_done),
        .illegal(illegal)
    );

    assign en = {mem_req, mem_write, ir_write, pc_write, reg_write, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        rw_seen = rw_seen | reg_write;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; mem_ready = 1; zero = 0; opcode = OP_R; funct3 = 0; rw_seen = 0;
        step;
        n_chk++;
        if (en !== 6'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_enables: en=%b illegal=%b, want en=000000 illegal=0", en, illegal); end
        n_chk++;
        if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL reset_state: state=%0d, want %0d", dut.state_q, S_FETCH); end
        rst = 0; mem_ready = 0; #1;
        n_chk++;
        if (mem_req !== 1 || ir_write !== 0 || pc_write !== 0 || adr_src !== 0 || alu_src_b !== 2'b10 || result_src !== 2'b10)
            begin n_fail++; $display("FAIL fetch_stall: req=%b irw=%b pcw=%b adr=%b b=%b res=%b, want 1 0 0 0 10 10", mem_req, ir_write, pc_write, adr_src, alu_src_b, result_src); end
        step;
        n_chk++;
        if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL fetch_hold: state=%0d, want %0d", dut.state_q, S_FETCH); end
    endtask

    task automatic test_add;
        opcode = OP_R; funct3 = 3'b000; mem_ready = 1; done_cnt = 0; #1;
        n_chk++;
        if (dut.state_q !== S_FETCH || ir_write !== 1 || pc_write !== 1 || mem_req !== 1)
            begin n_fail++; $display("FAIL add_fetch: state=%0d irw=%b pcw=%b req=%b, want %0d 1 1 1", dut.state_q, ir_write, pc_write, mem_req, S_FETCH); end
        done_cnt += int'(instr_done);
        step;
        n_chk++;
        if (dut.state_q !== S_DECODE || alu_src_a !== 2'b01 || alu_src_b !== 2'b01 || imm_src !== 3'b010 || alu_op !== 2'b00)
            begin n_fail++; $display("FAIL add_decode: state=%0d a=%b b=%b imm=%b op=%b, want %0d 01 01 010 00", dut.state_q, alu_src_a, alu_src_b, imm_src, alu_op, S_DECODE); end
        done_cnt += int'(instr_done);
        step;
        n_chk++;
        if (dut.state_q !== S_EXECR || alu_op !== 2'b10 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00 || reg_write !== 0)
            begin n_fail++; $display("FAIL add_execr: state=%0d op=%b a=%b b=%b rw=%b, want %0d 10 10 00 0", dut.state_q, alu_op, alu_src_a, alu_src_b, reg_write, S_EXECR); end
        done_cnt += int'(instr_done);
        step;
        n_chk++;
        if (dut.state_q !== S_ALUWB || reg_write !== 1 || instr_done !== 1 || result_src !== 2'b00)
            begin n_fail++; $display("FAIL add_aluwb: state=%0d rw=%b done=%b res=%b, want %0d 1 1 00", dut.state_q, reg_write, instr_done, result_src, S_ALUWB); end
        done_cnt += int'(instr_done);
        step;
        n_chk++;
        if (dut.state_q !== S_FETCH || done_cnt !== 1)
            begin n_fail++; $display("FAIL add_done_once: state=%0d done_cnt=%0d, want %0d 1", dut.state_q, done_cnt, S_FETCH); end
    endtask

    task automatic test_lw_stall;
        opcode = OP_LOAD; funct3 = 3'b010; mem_ready = 1; #1;
        step; step;
        n_chk++;
        if (dut.state_q !== S_MEMADR || alu_src_a !== 2'b10 || alu_src_b !== 2'b01 || imm_src !== 3'b000)
            begin n_fail++; $display("FAIL lw_memadr: state=%0d a=%b b=%b imm=%b, want %0d 10 01 000", dut.state_q, alu_src_a, alu_src_b, imm_src, S_MEMADR); end
        mem_ready = 0;
        step;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (dut.state_q !== S_MEMREAD || mem_req !== 1 || adr_src !== 1 || instr_done !== 0 || reg_write !== 0)
                begin n_fail++; $display("FAIL lw_stall%0d: state=%0d req=%b adr=%b done=%b rw=%b, want %0d 1 1 0 0", i, dut.state_q, mem_req, adr_src, instr_done, reg_write, S_MEMREAD); end
            step;
        end
        mem_ready = 1; #1;
        n_chk++;
        if (dut.state_q !== S_MEMREAD || mem_req !== 1)
            begin n_fail++; $display("FAIL lw_ready: state=%0d req=%b, want %0d 1", dut.state_q, mem_req, S_MEMREAD); end
        step;
        n_chk++;
        if (dut.state_q !== S_MEMWB || result_src !== 2'b01 || reg_write !== 1 || instr_done !== 1 || mem_req !== 0)
            begin n_fail++; $display("FAIL lw_memwb: state=%0d res=%b rw=%b done=%b req=%b, want %0d 01 1 1 0", dut.state_q, result_src, reg_write, instr_done, mem_req, S_MEMWB); end
        step;
        n_chk++;
        if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL lw_return: state=%0d, want %0d", dut.state_q, S_FETCH); end
    endtask

    task automatic test_branch;
        logic [2:0] f3_t [3] = '{3'b000, 3'b001, 3'b001};
        logic       z_t  [3] = '{1'b1, 1'b1, 1'b0};
        logic       pc_t [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            opcode = OP_BR; funct3 = f3_t[i]; zero = z_t[i]; mem_ready = 1; #1;
            step; step;
            n_chk++;
            if (dut.state_q !== S_BRANCH || pc_write !== pc_t[i] || instr_done !== 1 || alu_op !== 2'b01 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00)
                begin n_fail++; $display("FAIL branch%0d: state=%0d pcw=%b done=%b op=%b a=%b b=%b, want %0d %b 1 01 10 00", i, dut.state_q, pc_write, instr_done, alu_op, alu_src_a, alu_src_b, S_BRANCH, pc_t[i]); end
            step;
            n_chk++;
            if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL branch%0d_return: state=%0d, want %0d", i, dut.state_q, S_FETCH); end
        end
        funct3 = 3'b010; zero = 1; #1;
        step; step;
        n_chk++;
        if (dut.state_q !== S_BRANCH || pc_write !== 0 || instr_done !== 0)
            begin n_fail++; $display("FAIL branch_bad_f3: state=%0d pcw=%b done=%b, want %0d 0 0", dut.state_q, pc_write, instr_done, S_BRANCH); end
        step;
        n_chk++;
        if (dut.state_q !== S_ILLEGAL || illegal !== 1 || en !== 6'b0)
            begin n_fail++; $display("FAIL branch_illegal: state=%0d illegal=%b en=%b, want %0d 1 000000", dut.state_q, illegal, en, S_ILLEGAL); end
        rst = 1; step; rst = 0; zero = 0; #1;
        n_chk++;
        if (dut.state_q !== S_FETCH || illegal !== 0)
            begin n_fail++; $display("FAIL branch_recover: state=%0d illegal=%b, want %0d 0", dut.state_q, illegal, S_FETCH); end
    endtask

    task automatic test_addi_srai;
        logic [2:0] f3_t [2] = '{3'b000, 3'b101};
        logic [1:0] op_t [2] = '{2'b00, 2'b10};
        for (int i = 0; i < 2; i++) begin
            opcode = OP_I; funct3 = f3_t[i]; mem_ready = 1; #1;
            step; step;
            n_chk++;
            if (dut.state_q !== S_EXECI || alu_op !== op_t[i] || alu_src_a !== 2'b10 || alu_src_b !== 2'b01 || imm_src !== 3'b000)
                begin n_fail++; $display("FAIL execi%0d: state=%0d op=%b a=%b b=%b imm=%b, want %0d %b 10 01 000", i, dut.state_q, alu_op, alu_src_a, alu_src_b, imm_src, S_EXECI, op_t[i]); end
            step;
            n_chk++;
            if (dut.state_q !== S_ALUWB || reg_write !== 1 || instr_done !== 1)
                begin n_fail++; $display("FAIL execi%0d_wb: state=%0d rw=%b done=%b, want %0d 1 1", i, dut.state_q, reg_write, instr_done, S_ALUWB); end
            step;
        end
    endtask

    task automatic test_sw;
        opcode = OP_STORE; funct3 = 3'b010; mem_ready = 1; rw_seen = 0; #1;
        step; step;
        n_chk++;
        if (dut.state_q !== S_MEMADR || imm_src !== 3'b001)
            begin n_fail++; $display("FAIL sw_memadr: state=%0d imm=%b, want %0d 001", dut.state_q, imm_src, S_MEMADR); end
        mem_ready = 0;
        step;
        n_chk++;
        if (dut.state_q !== S_MEMWRITE || mem_req !== 1 || mem_write !== 1 || adr_src !== 1 || instr_done !== 0)
            begin n_fail++; $display("FAIL sw_stall: state=%0d req=%b wr=%b adr=%b done=%b, want %0d 1 1 1 0", dut.state_q, mem_req, mem_write, adr_src, instr_done, S_MEMWRITE); end
        step;
        mem_ready = 1; #1;
        n_chk++;
        if (dut.state_q !== S_MEMWRITE || mem_write !== 1 || instr_done !== 1)
            begin n_fail++; $display("FAIL sw_ready: state=%0d wr=%b done=%b, want %0d 1 1", dut.state_q, mem_write, instr_done, S_MEMWRITE); end
        step;
        n_chk++;
        if (dut.state_q !== S_FETCH || rw_seen !== 0)
            begin n_fail++; $display("FAIL sw_end: state=%0d reg_write_seen=%b, want %0d 0", dut.state_q, rw_seen, S_FETCH); end
    endtask

    task automatic test_jal_lui;
        opcode = OP_JAL; funct3 = 3'b000; mem_ready = 1; #1;
        step; step;
        n_chk++;
        if (dut.state_q !== S_JAL || pc_write !== 1 || reg_write !== 0 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10 || imm_src !== 3'b011 || result_src !== 2'b00)
            begin n_fail++; $display("FAIL jal: state=%0d pcw=%b rw=%b a=%b b=%b imm=%b res=%b, want %0d 1 0 01 10 011 00", dut.state_q, pc_write, reg_write, alu_src_a, alu_src_b, imm_src, result_src, S_JAL); end
        step;
        n_chk++;
        if (dut.state_q !== S_ALUWB || reg_write !== 1 || instr_done !== 1 || pc_write !== 0)
            begin n_fail++; $display("FAIL jal_wb: state=%0d rw=%b done=%b pcw=%b, want %0d 1 1 0", dut.state_q, reg_write, instr_done, pc_write, S_ALUWB); end
        step;
        opcode = OP_LUI; #1;
        step; step;
        n_chk++;
        if (dut.state_q !== S_LUI || alu_src_a !== 2'b11 || alu_src_b !== 2'b01 || imm_src !== 3'b100 || alu_op !== 2'b00)
            begin n_fail++; $display("FAIL lui: state=%0d a=%b b=%b imm=%b op=%b, want %0d 11 01 100 00", dut.state_q, alu_src_a, alu_src_b, imm_src, alu_op, S_LUI); end
        step; step;
        n_chk++;
        if (dut.state_q !== S_FETCH) begin n_fail++; $display("FAIL lui_return: state=%0d, want %0d", dut.state_q, S_FETCH); end
    endtask

    task automatic test_illegal_opcode;
        opcode = 7'h7F; mem_ready = 1; #1;
        step; step;
        for (int i = 0; i < 10; i++) begin
            zero = i[0];
            #1;
            n_chk++;
            if (dut.state_q !== S_ILLEGAL || illegal !== 1 || en !== 6'b0)
                begin n_fail++; $display("FAIL illegal_cyc%0d: state=%0d illegal=%b en=%b, want %0d 1 000000", i, dut.state_q, illegal, en, S_ILLEGAL); end
            step;
        end
        rst = 1; step; rst = 0; zero = 0; #1;
    endtask

    task automatic test_rst_mid;
        opcode = OP_LOAD; funct3 = 3'b010; mem_ready = 1; rw_seen = 0; #1;
        step; step;
        mem_ready = 0;
        step;
        n_chk++;
        if (dut.state_q !== S_MEMREAD || mem_req !== 1)
            begin n_fail++; $display("FAIL rstmid_pre: state=%0d req=%b, want %0d 1", dut.state_q, mem_req, S_MEMREAD); end
        rst = 1; #1;
        n_chk++;
        if (mem_req !== 0 || en !== 6'b0)
            begin n_fail++; $display("FAIL rstmid_req_drop: req=%b en=%b, want 0 000000", mem_req, en); end
        step;
        rst = 0; #1;
        n_chk++;
        if (dut.state_q !== S_FETCH || mem_req !== 1 || rw_seen !== 0)
            begin n_fail++; $display("FAIL rstmid_fetch: state=%0d req=%b reg_write_seen=%b, want %0d 1 0", dut.state_q, mem_req, rw_seen, S_FETCH); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        test_reset;
        test_add;
        test_lw_stall;
        test_branch;
        test_addi_srai;
        test_sw;
        test_jal_lui;
        test_illegal_opcode;
        test_rst_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
